coin_collect: RTL
=================

# coin_collect

Per-frame collision and scoring stage. It sits beside the pixel mux in the game top, consuming the player position from `player`, plus the coin positions and activity fields from `coin`. Once per video frame it checks the player box against each of three coin boxes and emits one-cycle collect pulses. It also accumulates a 4-digit BCD score for the score overlay and for the coin block's despawn logic.

## Interface
- `PLAYER_W`, 120: player box width in pixels.
- `PLAYER_H`, 40: player box height in pixels.
- `COIN_SIZE`, 50: coin box side in pixels.
- `COMBO_WINDOW`, 60: frames allowed between hits to keep a combo (combo build only).
- `i_clk` in 1: system clock, 100 MHz.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_frame` in 1: one-cycle strobe at vblank start (from `vga640x480` timing).
- `player_x` in 10: player box left edge.
- `player_y` in 9: player box top edge.
- `coins_x` in 30: coin k left edge at [10k+9:10k], k = 0..2.
- `coins_y` in 27: coin k top edge at [9k+8:9k].
- `coins` in 6: coin k value at [2k+1:2k]; 0 means inactive, 1..3 gives points.
- `o_hit` out 3: bit k pulses for one cycle when coin k is collected.
- `o_score` out 16: BCD score, 4 digits, saturates at 9999.
- `o_busy` out 1: high while the FSM is not in IDLE.

## Operation
- FSM states: IDLE, CHK0, CHK1, CHK2, SCORE.
  - IDLE to CHK0 on `i_frame`. CHKk to the next state unconditionally. SCORE to IDLE.
- On `i_frame` in IDLE, snapshot all position and value inputs into registers. Later input changes do not affect this frame.
- CHKk, using the snapshot:
  - Overlap is strict on all four edges: `cx < px+PLAYER_W`, `px < cx+COIN_SIZE`, `cy < py+PLAYER_H`, `py < cy+COIN_SIZE`.
  - Sums are computed at 11 bits (x) and 10 bits (y), so boxes near the screen edge never wrap.
  - A hit requires: value != 0, overlap, and `taken[k]` = 0.
  - On a hit: set `pend[k]`, set `taken[k]`, and add the value to a 5-bit points accumulator.
- `taken[k]` clears in any CHKk that sees value = 0. A coin therefore scores once per appearance, even if it overlaps the player for several frames.
- SCORE:
  - `o_hit <= pend` for one cycle, then `pend` clears.
  - Add the accumulator (0..18) to `o_score` in one cycle using a BCD digit carry chain.
  - If the result exceeds 9999, `o_score` = 9999.
  - Clear the accumulator.
- `i_frame` while busy is ignored; it is not queued.

## Timing
- Reset values: `o_hit` = 0, `o_score` = 0, `o_busy` = 0, FSM in IDLE. `taken`, `pend`, the accumulator and the snapshot registers are all 0.
- `i_frame` sampled high at edge t:
  - CHK0 occupies t+1, CHK1 t+2, CHK2 t+3, SCORE t+4.
  - `o_hit` is high during t+5 only.
  - `o_score` shows the new value from t+5 onward.
- `o_busy` is high from t+1 through t+4.
- Minimum spacing between frames is 5 cycles; real spacing is about 1.67 M cycles.
- Reset asserted mid-frame returns everything to reset values immediately. No partial score is committed.

## Configuration
- `COIN_COLLECT_COMBO_EN` defined:
  - Add a frame counter (saturating at `COMBO_WINDOW`) and a combo count (saturating at 3).
  - A frame with at least one hit increments combo if the counter < `COMBO_WINDOW`; otherwise combo is set to 1. The counter then resets to 0.
  - In SCORE, when combo >= 3 the accumulator is doubled before the add.
  - Reset clears both the counter and the combo count.
- Undefined: no combo logic, points always 1x.

## Structure
- Shared package `game_pkg` holds:
  - localparams: `SCREEN_W` = 640, `SCREEN_H` = 480, `NUM_COINS` = 3, coin field widths;
  - the FSM state enum;
  - the BCD digit type.
- One sub-module, `bcd_add4`: combinational 4-digit BCD plus 0..18 with saturation, reused by the score overlay.

## Test plan
- Reset, then one frame with player (100,200) and coin0 (150,210) value 2, others 0 → `o_hit` = 3'b001 at t+5, `o_score` = 0x0002.
- Same positions held for 3 frames → exactly one hit. Then set coin0 value to 0 for one frame and back to 2 → a second hit, score 0x0004.
- Edge touch: coin0 x = 220 (= px + 120) → no hit. Coin0 x = 219 → hit.
- All three coins overlapping, values 3/3/3, starting score 0x9995 → `o_hit` = 3'b111, score saturates at 0x9999.
- `i_frame` pulsed again at t+2 → ignored, only one scoring pass. Reset at t+3 → score 0, `o_hit` never pulses.
- With `COIN_COLLECT_COMBO_EN`: hits on 3 frames spaced 10 frames apart, value 1 each → scores 1, 2, 4. A fourth hit 100 frames later adds 1.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: screen geometry, coin field widths, collision FSM
// states and the BCD digit type used by the score logic and the overlay.
// Pure declarations; no ports, no latency, no flow control.
package game_pkg;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int NUM_COINS = 3;
  localparam int COIN_X_W  = 10;
  localparam int COIN_Y_W  = 9;
  localparam int COIN_V_W  = 2;
  localparam int PTS_W     = 5;   // per-frame points, 0..18

  // One extra bit so position + box size never wraps near the screen edge.
  typedef logic [COIN_X_W:0] xsum_t;
  typedef logic [COIN_Y_W:0] ysum_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHK0  = 3'd1,
    ST_CHK1  = 3'd2,
    ST_CHK2  = 3'd3,
    ST_SCORE = 3'd4
  } state_t;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_add4.sv
// 4-digit BCD score plus a small binary addend (0..99), saturating at 9999.
// Purely combinational, zero latency; no flow control.
// Ports: a = BCD score in, b = binary addend, sum = saturated BCD result.
module bcd_add4
  import game_pkg::*;
#(
  parameter int ADD_W = 6
) (
  input  logic [15:0]      a,
  input  logic [ADD_W-1:0] b,
  output logic [15:0]      sum
);

  bcd_digit_t b_ones;
  bcd_digit_t b_tens;
  bcd_digit_t add_d;
  logic [4:0] t;
  logic       c;

  always_comb begin
    // Split the binary addend into two BCD digits, then ripple digit carries.
    b_ones = bcd_digit_t'(b % 10);
    b_tens = bcd_digit_t'(b / 10);
    add_d  = '0;
    t      = '0;
    c      = 1'b0;
    sum    = '0;
    for (int i = 0; i < 4; i++) begin
      add_d = (i == 0) ? b_ones : ((i == 1) ? b_tens : 4'd0);
      t = {1'b0, a[4*i +: 4]} + {1'b0, add_d} + {4'b0, c};
      if (t > 5'd9) begin
        sum[4*i +: 4] = 4'(t - 5'd10);
        c = 1'b1;
      end else begin
        sum[4*i +: 4] = t[3:0];
        c = 1'b0;
      end
    end
    // Carry out of the thousands digit means the true result passed 9999.
    if (c) sum = 16'h9999;
  end

endmodule

// File: rtl/coin_collect.sv
// Per-frame player/coin collision check and BCD score accumulation.
// Latency: i_frame at edge t -> o_hit pulse and new o_score in cycle t+5; busy t+1..t+4.
// Backpressure: none; i_frame while busy is dropped, not queued.
// Ports: i_clk/i_rst, i_frame strobe, player_x/y, coins_x/y/coins snapshot inputs,
//        o_hit (per-coin collect pulse), o_score (BCD), o_busy.
// Optional COIN_COLLECT_COMBO_EN: combo tracking doubles points on the 3rd+ quick hit.
module coin_collect
  import game_pkg::*;
#(
  parameter int PLAYER_W  = 120,
  parameter int PLAYER_H  = 40,
  parameter int COIN_SIZE = 50
`ifdef COIN_COLLECT_COMBO_EN
  ,
  parameter int COMBO_WINDOW = 60
`endif
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_frame,
  input  logic [COIN_X_W-1:0]             player_x,
  input  logic [COIN_Y_W-1:0]             player_y,
  input  logic [NUM_COINS*COIN_X_W-1:0]   coins_x,
  input  logic [NUM_COINS*COIN_Y_W-1:0]   coins_y,
  input  logic [NUM_COINS*COIN_V_W-1:0]   coins,
  output logic [NUM_COINS-1:0]            o_hit,
  output logic [15:0]                     o_score,
  output logic                            o_busy
);

  state_t                          state;
  logic [COIN_X_W-1:0]             snap_px;
  logic [COIN_Y_W-1:0]             snap_py;
  logic [NUM_COINS*COIN_X_W-1:0]   snap_cx;
  logic [NUM_COINS*COIN_Y_W-1:0]   snap_cy;
  logic [NUM_COINS*COIN_V_W-1:0]   snap_cv;
  logic [NUM_COINS-1:0]            taken;
  logic [NUM_COINS-1:0]            pend;
  logic [PTS_W-1:0]                acc;

  logic [NUM_COINS-1:0]            sel;
  logic [COIN_X_W-1:0]             cx;
  logic [COIN_Y_W-1:0]             cy;
  logic [COIN_V_W-1:0]             cv;
  logic                            is_chk;
  logic                            overlap;
  logic                            hit_now;
  logic [PTS_W:0]                  add_pts;
  logic [15:0]                     score_sum;

  assign o_busy = (state != ST_IDLE);

  // Select the snapshot fields of the coin handled by the current CHK state.
  always_comb begin
    sel    = 3'b001;
    cx     = snap_cx[COIN_X_W-1:0];
    cy     = snap_cy[COIN_Y_W-1:0];
    cv     = snap_cv[COIN_V_W-1:0];
    is_chk = 1'b1;
    case (state)
      ST_CHK0: ;
      ST_CHK1: begin
        sel = 3'b010;
        cx  = snap_cx[2*COIN_X_W-1:COIN_X_W];
        cy  = snap_cy[2*COIN_Y_W-1:COIN_Y_W];
        cv  = snap_cv[2*COIN_V_W-1:COIN_V_W];
      end
      ST_CHK2: begin
        sel = 3'b100;
        cx  = snap_cx[3*COIN_X_W-1:2*COIN_X_W];
        cy  = snap_cy[3*COIN_Y_W-1:2*COIN_Y_W];
        cv  = snap_cv[3*COIN_V_W-1:2*COIN_V_W];
      end
      default: is_chk = 1'b0;
    endcase
  end

  // Strict overlap on all four edges; touching boxes do not collide.
  assign overlap = (xsum_t'(cx) < xsum_t'(snap_px) + xsum_t'(PLAYER_W)) &&
                   (xsum_t'(snap_px) < xsum_t'(cx) + xsum_t'(COIN_SIZE)) &&
                   (ysum_t'(cy) < ysum_t'(snap_py) + ysum_t'(PLAYER_H)) &&
                   (ysum_t'(snap_py) < ysum_t'(cy) + ysum_t'(COIN_SIZE));

  assign hit_now = is_chk && (cv != '0) && overlap && ((taken & sel) == '0);

`ifdef COIN_COLLECT_COMBO_EN
  localparam int CNT_W = $clog2(COMBO_WINDOW + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  cnt_t       frame_cnt;   // frames since the last scoring frame, saturating
  logic [1:0] combo;
  logic [1:0] combo_nxt;

  // The combo including this frame's hit decides whether this frame doubles.
  always_comb begin
    combo_nxt = combo;
    if (pend != '0) begin
      if (frame_cnt < cnt_t'(COMBO_WINDOW))
        combo_nxt = (combo == 2'd3) ? 2'd3 : combo + 2'd1;
      else
        combo_nxt = 2'd1;
    end
    add_pts = (combo_nxt == 2'd3) ? {acc, 1'b0} : {1'b0, acc};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frame_cnt <= '0;
      combo     <= '0;
    end else if (state == ST_SCORE) begin
      combo <= combo_nxt;
      if (pend != '0)
        frame_cnt <= '0;
      else if (frame_cnt < cnt_t'(COMBO_WINDOW))
        frame_cnt <= frame_cnt + cnt_t'(1);
    end
  end
`else
  assign add_pts = {1'b0, acc};
`endif

  bcd_add4 #(.ADD_W(PTS_W + 1)) u_bcd_add4 (
    .a   (o_score),
    .b   (add_pts),
    .sum (score_sum)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      snap_px <= '0;
      snap_py <= '0;
      snap_cx <= '0;
      snap_cy <= '0;
      snap_cv <= '0;
      taken   <= '0;
      pend    <= '0;
      acc     <= '0;
      o_hit   <= '0;
      o_score <= '0;
    end else begin
      o_hit <= '0;
      case (state)
        ST_IDLE: begin
          if (i_frame) begin
            snap_px <= player_x;
            snap_py <= player_y;
            snap_cx <= coins_x;
            snap_cy <= coins_y;
            snap_cv <= coins;
            state   <= ST_CHK0;
          end
        end
        ST_CHK0, ST_CHK1, ST_CHK2: begin
          // An inactive coin re-arms its slot so the next appearance can score.
          if (cv == '0) begin
            taken <= taken & ~sel;
          end else if (hit_now) begin
            taken <= taken | sel;
            pend  <= pend | sel;
            acc   <= acc + {3'b000, cv};
          end
          if (state == ST_CHK0)      state <= ST_CHK1;
          else if (state == ST_CHK1) state <= ST_CHK2;
          else                       state <= ST_SCORE;
        end
        ST_SCORE: begin
          o_hit   <= pend;
          pend    <= '0;
          o_score <= score_sum;
          acc     <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
